// File: rtl/top2_pkg.sv
// Shared types for the frame controller: FSM state encoding.
package top2_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      EMIT  = 2'd2
   } state_e;

endpackage

// File: rtl/top2_frame_ctrl_if.sv
// Sample-in / result-out handshake bundle of the frame controller.
interface top2_frame_ctrl_if #(
   parameter int DATA_WIDTH = 32,
   parameter int LEN_WIDTH  = 8
);

   logic [LEN_WIDTH-1:0]  cfg_len;
   logic                  in_valid;
   logic                  in_ready;
   logic [DATA_WIDTH-1:0] in_data;
   logic                  in_last;
   logic                  out_valid;
   logic                  out_ready;
   logic [DATA_WIDTH-1:0] out_max;
   logic [DATA_WIDTH-1:0] out_second;
   logic [LEN_WIDTH:0]    out_count;

   modport master (
      output cfg_len, in_valid, in_data, in_last, out_ready,
      input  in_ready, out_valid, out_max, out_second, out_count
   );

   modport slave (
      input  cfg_len, in_valid, in_data, in_last, out_ready,
      output in_ready, out_valid, out_max, out_second, out_count
   );

endinterface

// File: rtl/top2_tracker.sv
// Largest / second-largest tracker; load seeds a frame, update folds in a sample.
module top2_tracker #(
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  load,
   input  logic                  update,
   input  logic [DATA_WIDTH-1:0] din,
   output logic [DATA_WIDTH-1:0] big1,
   output logic [DATA_WIDTH-1:0] big2
);

   logic [DATA_WIDTH-1:0] big1_q, big1_d;
   logic [DATA_WIDTH-1:0] big2_q, big2_d;

   always_comb begin
      big1_d = big1_q;
      big2_d = big2_q;
      if (load) begin
         big1_d = din;
         big2_d = '0;
      end else if (update) begin
         // ties shift down so duplicates occupy both slots
         if (din >= big1_q) begin
            big1_d = din;
            big2_d = big1_q;
         end else if (din >= big2_q) begin
            big2_d = din;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         big1_q <= '0;
         big2_q <= '0;
      end else begin
         big1_q <= big1_d;
         big2_q <= big2_d;
      end
   end

   assign big1 = big1_q;
   assign big2 = big2_q;

endmodule

// File: rtl/top2_frame_ctrl.sv
// Frame sequencer: cuts the sample stream into frames and emits max/second/count.
module top2_frame_ctrl
   import top2_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int LEN_WIDTH  = 8
) (
   input logic               clk,
   input logic               reset,
   top2_frame_ctrl_if.slave  bus
);

   localparam logic [LEN_WIDTH-1:0] LEN_ONE = {{(LEN_WIDTH-1){1'b0}}, 1'b1};
   localparam logic [LEN_WIDTH:0]   CNT_ONE = {{LEN_WIDTH{1'b0}}, 1'b1};

   state_e               state_q, state_d;
   logic [LEN_WIDTH-1:0] len_q, len_d;
   logic [LEN_WIDTH:0]   count_q, count_d;
   logic [LEN_WIDTH-1:0] eff_len;
   logic                 in_ready;
   logic                 out_valid;
   logic                 accept;
   logic                 load;
   logic                 update;
   logic [DATA_WIDTH-1:0] big1;
   logic [DATA_WIDTH-1:0] big2;

   assign in_ready  = !reset && (state_q != EMIT);
   assign out_valid = !reset && (state_q == EMIT);
   assign accept    = bus.in_valid && in_ready;
   assign eff_len   = (bus.cfg_len == '0) ? LEN_ONE : bus.cfg_len;

   always_comb begin
      state_d = state_q;
      len_d   = len_q;
      count_d = count_q;
      load    = 1'b0;
      update  = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (accept) begin
               len_d   = eff_len;
               count_d = CNT_ONE;
               load    = 1'b1;
               if (eff_len == LEN_ONE || bus.in_last) state_d = EMIT;
               else                                   state_d = ACCUM;
            end
         end
         ACCUM: begin
            if (accept) begin
               count_d = count_q + 1'b1;
               update  = 1'b1;
               if (count_d == {1'b0, len_q} || bus.in_last) state_d = EMIT;
            end
         end
         EMIT: begin
            if (bus.out_ready) begin
               state_d = IDLE;
               count_d = '0;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         len_q   <= '0;
         count_q <= '0;
      end else begin
         state_q <= state_d;
         len_q   <= len_d;
         count_q <= count_d;
      end
   end

   top2_tracker #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_tracker (
      .clk    (clk),
      .reset  (reset),
      .load   (load),
      .update (update),
      .din    (bus.in_data),
      .big1   (big1),
      .big2   (big2)
   );

   assign bus.in_ready   = in_ready;
   assign bus.out_valid  = out_valid;
   assign bus.out_max    = out_valid ? big1 : '0;
   assign bus.out_second = out_valid ? big2 : '0;
   assign bus.out_count  = out_valid ? count_q : '0;

endmodule

// File: tb/tb_top2_frame_ctrl.sv
// Directed vector bench for top2_frame_ctrl.
module tb_top2_frame_ctrl;

   localparam int DW = 32;
   localparam int LW = 8;

   typedef struct {
      logic          rst;
      logic          iv;
      logic [DW-1:0] d;
      logic          il;
      logic [LW-1:0] cfg;
      logic          ordy;
      logic          ir;
      logic          ov;
      logic [DW-1:0] mx;
      logic [DW-1:0] sc;
      logic [LW:0]   cnt;
   } vec_t;

   logic clk;
   logic reset;
   int   checks;
   int   errors;
   vec_t vecs[$];

   top2_frame_ctrl_if #(.DATA_WIDTH(DW), .LEN_WIDTH(LW)) bus ();

   top2_frame_ctrl #(.DATA_WIDTH(DW), .LEN_WIDTH(LW)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [DW-1:0] act,
                      input logic [DW-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic add(input logic rst, input logic iv, input int d,
                      input logic il, input int cfg, input logic ordy,
                      input logic ir, input logic ov, input int mx,
                      input int sc, input int cnt);
      vec_t v;
      v.rst = rst; v.iv = iv; v.d = DW'(d); v.il = il;
      v.cfg = LW'(cfg); v.ordy = ordy; v.ir = ir; v.ov = ov;
      v.mx = DW'(mx); v.sc = DW'(sc); v.cnt = (LW+1)'(cnt);
      vecs.push_back(v);
   endtask

   task automatic drive(input logic rst, input logic iv, input int d,
                        input logic il, input int cfg, input logic ordy);
      reset         = rst;
      bus.in_valid  = iv;
      bus.in_data   = DW'(d);
      bus.in_last   = il;
      bus.cfg_len   = LW'(cfg);
      bus.out_ready = ordy;
   endtask

   initial begin
      reset         = 1'b1;
      bus.in_valid  = 1'b0;
      bus.in_data   = '0;
      bus.in_last   = 1'b0;
      bus.cfg_len   = '0;
      bus.out_ready = 1'b0;
      checks = 0;
      errors = 0;

      //  rst iv  d  il cfg rdy  ir ov max sec cnt
      add(1, 0,  0, 0, 0, 0,   0, 0, 0,  0,  0);
      // 3,9,1,7 with len 4
      add(0, 1,  3, 0, 4, 1,   1, 0, 0,  0,  0);
      add(0, 1,  9, 0, 4, 1,   1, 0, 0,  0,  0);
      add(0, 1,  1, 0, 4, 1,   1, 0, 0,  0,  0);
      add(0, 1,  7, 0, 4, 1,   1, 0, 0,  0,  0);
      add(0, 0,  0, 0, 4, 1,   0, 1, 9,  7,  4);
      add(0, 0,  0, 0, 4, 1,   1, 0, 0,  0,  0);
      // ties 5,5,2
      add(0, 1,  5, 0, 3, 1,   1, 0, 0,  0,  0);
      add(0, 1,  5, 0, 3, 1,   1, 0, 0,  0,  0);
      add(0, 1,  2, 0, 3, 1,   1, 0, 0,  0,  0);
      add(0, 0,  0, 0, 3, 1,   0, 1, 5,  5,  3);
      // early in_last, then cfg 0 single sample
      add(0, 1,  4, 0, 10, 1,  1, 0, 0,  0,  0);
      add(0, 1,  8, 1, 10, 1,  1, 0, 0,  0,  0);
      add(0, 0,  0, 0, 10, 1,  0, 1, 8,  4,  2);
      add(0, 1,  6, 0, 0, 1,   1, 0, 0,  0,  0);
      add(0, 0,  0, 0, 0, 1,   0, 1, 6,  0,  1);
      // backpressure: five stalled EMIT cycles with pending input
      add(0, 1,  1, 0, 2, 1,   1, 0, 0,  0,  0);
      add(0, 1,  2, 0, 2, 0,   1, 0, 0,  0,  0);
      for (int i = 0; i < 5; i++)
         add(0, 1, 99, 0, 2, 0,  0, 1, 2,  1,  2);
      add(0, 1, 99, 0, 2, 1,   0, 1, 2,  1,  2);
      add(0, 1, 50, 0, 1, 1,   1, 0, 0,  0,  0);
      add(0, 0,  0, 0, 1, 1,   0, 1, 50, 0,  1);
      // gaps, cfg changed mid-frame
      add(0, 1, 10, 0, 4, 1,   1, 0, 0,  0,  0);
      add(0, 0, 77, 0, 2, 1,   1, 0, 0,  0,  0);
      add(0, 1, 20, 0, 2, 1,   1, 0, 0,  0,  0);
      add(0, 0,  0, 0, 2, 1,   1, 0, 0,  0,  0);
      add(0, 1, 15, 0, 2, 1,   1, 0, 0,  0,  0);
      add(0, 0,  0, 0, 2, 1,   1, 0, 0,  0,  0);
      add(0, 1,  5, 0, 2, 1,   1, 0, 0,  0,  0);
      add(0, 0,  0, 0, 2, 1,   0, 1, 20, 15, 4);
      // reset mid-frame
      add(0, 1,  8, 0, 4, 1,   1, 0, 0,  0,  0);
      add(0, 1,  6, 0, 4, 1,   1, 0, 0,  0,  0);
      add(1, 0,  0, 0, 4, 1,   0, 0, 0,  0,  0);
      add(0, 1,  1, 0, 2, 1,   1, 0, 0,  0,  0);
      add(0, 1,  2, 0, 2, 1,   1, 0, 0,  0,  0);
      add(0, 0,  0, 0, 2, 1,   0, 1, 2,  1,  2);
      add(0, 0,  0, 0, 2, 1,   1, 0, 0,  0,  0);
      // reset mid-EMIT drops the result
      add(0, 1,  3, 0, 1, 0,   1, 0, 0,  0,  0);
      add(1, 0,  0, 0, 1, 0,   0, 0, 0,  0,  0);
      add(0, 0,  0, 0, 1, 1,   1, 0, 0,  0,  0);
      add(0, 0,  0, 0, 1, 1,   1, 0, 0,  0,  0);

      foreach (vecs[i]) begin
         @(negedge clk);
         drive(vecs[i].rst, vecs[i].iv, int'(vecs[i].d), vecs[i].il,
               int'(vecs[i].cfg), vecs[i].ordy);
         #1;
         chk($sformatf("v%0d in_ready", i),  DW'(bus.in_ready),  DW'(vecs[i].ir));
         chk($sformatf("v%0d out_valid", i), DW'(bus.out_valid), DW'(vecs[i].ov));
         chk($sformatf("v%0d out_max", i),   bus.out_max,        vecs[i].mx);
         chk($sformatf("v%0d out_second", i), bus.out_second,    vecs[i].sc);
         chk($sformatf("v%0d out_count", i), DW'(bus.out_count), DW'(vecs[i].cnt));
      end

      // longest frame: 255 ascending samples
      for (int i = 1; i <= 255; i++) begin
         @(negedge clk);
         drive(0, 1, i, 0, 255, 1);
         #1;
         if (i == 255) chk("long in_ready", DW'(bus.in_ready), 1);
      end
      @(negedge clk);
      drive(0, 0, 0, 0, 255, 1);
      #1;
      begin
         int waited;
         waited = 0;
         while (!bus.out_valid && waited < 4) begin
            @(negedge clk);
            #1;
            waited++;
         end
         chk("long latency", DW'(waited), 0);
      end
      chk("long out_valid", DW'(bus.out_valid), 1);
      chk("long out_max", bus.out_max, 255);
      chk("long out_second", bus.out_second, 254);
      chk("long out_count", DW'(bus.out_count), 255);
      @(negedge clk);
      #1;
      chk("long drop", DW'(bus.out_valid), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
